// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings (ALU_ADD .. ALU_MUL)
//   - FSM state encoding
//   - bit positions inside the registered flag vector
//   - MUL_EN mirrors the ALU_MUL_EN build macro so logic can test it as a constant
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_SRA = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1110;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Flag vector layout: {err, ovf, cout, zout}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_E = 3;
  localparam int FLAG_W = 4;

  // True only when the multiplier is built in and the opcode selects it.
  function automatic logic op_is_mul(input logic [3:0] op);
    return MUL_EN && (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle of the multi-cycle ALU.
//   Request : in_valid, in_ready, a, b, alu_ctrl, shamt
//   Response: out_valid, out_ready, result, zout, cout, ovf, err
//   Modports: slave  - the ALU itself
//             master - the issue/writeback side driving it
interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         alu_ctrl;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zout;
  logic               cout;
  logic               ovf;
  logic               err;

  modport slave (
    input  in_valid, a, b, alu_ctrl, shamt, out_ready,
    output in_ready, out_valid, result, zout, cout, ovf, err
  );

  modport master (
    output in_valid, a, b, alu_ctrl, shamt, out_ready,
    input  in_ready, out_valid, result, zout, cout, ovf, err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, low WIDTH bits, unsigned.
//   clk, reset : clock, asynchronous active-high reset (discards any run)
//   start      : load a/b and begin WIDTH iterations
//   a, b       : operands, sampled only on start
//   done       : one-cycle pulse, the cycle after the last iteration
//   product    : accumulator; valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain the updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q    <= a;
        b_q    <= b;
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (b_q[0]) acc_q <= acc_q + a_q;
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign done    = done_q;
  assign product = acc_q;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered flags.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_mc_if.slave (request operands/opcode, result and flags)
// Single-cycle ops produce out_valid one cycle after acceptance. When the
// build macro ALU_MUL_EN is defined, opcode MUL runs the iterative
// multiplier (alu_mul_iter) and completes WIDTH+1 cycles after acceptance;
// otherwise MUL is an illegal opcode.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);

  alu_state_e         state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [FLAG_W-1:0]  flags_q;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   result_d;
  logic [FLAG_W-1:0]  flags_d;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   b_op;
  logic               is_sub;
  logic [SHAMT_W-1:0] shamt;

  assign shamt    = bus.shamt;
  // Combinational from out_ready so a draining result can overlap with issue.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle datapath; works on the live inputs, which are only
  // consumed on the accepting edge.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned and infers a latch.
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    is_sub   = (bus.alu_ctrl == ALU_SUB);
    b_op     = is_sub ? ~bus.b : bus.b;
    // SUB is a + ~b + 1, so the carry out is NOT borrow.
    sum_w    = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    case (bus.alu_ctrl)
      ALU_ADD, ALU_SUB: begin
        result_d        = sum_w[WIDTH-1:0];
        flags_d[FLAG_C] = sum_w[WIDTH];
        // Overflow: both addends share a sign that the sum does not.
        flags_d[FLAG_V] = (bus.a[WIDTH-1] == b_op[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND: result_d = bus.a & bus.b;
      ALU_OR:  result_d = bus.a | bus.b;
      ALU_NOR: result_d = ~(bus.a | bus.b);
      ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLL: result_d = bus.b << shamt;
      ALU_SRL: result_d = bus.b >> shamt;
      ALU_SRA: result_d = $signed(bus.b) >>> shamt;
      // Illegal opcodes land here; a legal MUL never reaches DONE through
      // this path because the FSM routes it to the multiplier.
      default: flags_d[FLAG_E] = 1'b1;
    endcase
    flags_d[FLAG_Z] = (result_d == '0);
  end

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && op_is_mul(bus.alu_ctrl);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Result drained with no new request: fall back to IDLE.
          if ((state_q == ST_DONE) && bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
          // A request accepted this edge overrides the drain above.
          if (accept) begin
            if (op_is_mul(bus.alu_ctrl)) begin
              state_q     <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= result_d;
              flags_q     <= flags_d;
            end
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            state_q         <= ST_DONE;
            out_valid_q     <= 1'b1;
            result_q        <= mul_product;
            flags_q         <= '0;
            flags_q[FLAG_Z] <= (mul_product == '0);
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zout      = flags_q[FLAG_Z];
  assign bus.cout      = flags_q[FLAG_C];
  assign bus.ovf       = flags_q[FLAG_V];
  assign bus.err       = flags_q[FLAG_E];

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v, e;
    int           lat;
  } model_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         z, c, v, e;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic on wide integers.
  function automatic model_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] sh);
    model_t m;
    longint sa, sb, s;
    longint lim;
    longint unsigned ua, ub;
    lim = 64'sd2147483647;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    m.res = '0; m.c = 0; m.v = 0; m.e = 0; m.lat = 1;
    case (op)
      4'b0000: begin
        m.res = W'(ua + ub);
        m.c   = (ua + ub) > 64'hFFFF_FFFF;
        s     = sa + sb;
        m.v   = (s > lim) || (s < -lim - 1);
      end
      4'b0010: begin
        m.res = W'(ua - ub);
        m.c   = (ua >= ub);
        s     = sa - sb;
        m.v   = (s > lim) || (s < -lim - 1);
      end
      4'b0100: m.res = a & b;
      4'b0001: m.res = a | b;
      4'b0101: m.res = ~(a | b);
      4'b0111: m.res = (sa < sb) ? 1 : 0;
      4'b1010: m.res = W'(ub << sh);
      4'b1011: m.res = W'(ub >> sh);
      4'b1100: m.res = W'(sb >>> sh);
`ifdef ALU_MUL_EN
      4'b1110: begin
        m.res = W'(ua * ub);
        m.lat = W + 1;
      end
`endif
      default: m.e = 1;
    endcase
    m.z = (m.res == 0);
    return m;
  endfunction

  // Issue one op with out_ready high; report outputs and latency in cycles.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, output logic [W-1:0] res,
                        output logic [3:0] flg, output int lat, output logic ready_leak);
    int guard;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.alu_ctrl  = op;
    bus.a         = a;
    bus.b         = b;
    bus.shamt     = sh;
    bus.in_valid  = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    ready_leak = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
    flg = {bus.err, bus.ovf, bus.cout, bus.zout};
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    logic         leak;
    model_t       m;
    logic [3:0]   ops[10];
    logic [W-1:0] corner[5];

    bus.in_valid = 0; bus.out_ready = 1; bus.a = 0; bus.b = 0;
    bus.alu_ctrl = 0; bus.shamt = 0;
    reset = 1'b1;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_result",    bus.result, 0);
    check("rst_flags",     {bus.err, bus.ovf, bus.cout, bus.zout}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with hand-computed expectations.
    vecs.push_back('{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1, 1, 0, 0, 1});
    vecs.push_back('{"add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 0, 0, 1, 0, 1});
    vecs.push_back('{"sra",       4'b1100, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0, 0, 0, 0, 1});
    vecs.push_back('{"srl",       4'b1011, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 0, 0, 0, 0, 1});
    vecs.push_back('{"sll0",      4'b1010, 32'h0, 32'h1234, 5'd0, 32'h1234, 0, 0, 0, 0, 1});
    vecs.push_back('{"sub_neg",   4'b0010, 32'h5, 32'h7, 5'd0, 32'hFFFF_FFFE, 0, 0, 0, 0, 1});
    vecs.push_back('{"sub_pos",   4'b0010, 32'h7, 32'h5, 5'd0, 32'h2, 0, 1, 0, 0, 1});
    vecs.push_back('{"sub_ovf",   4'b0010, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 0, 1, 1, 0, 1});
    vecs.push_back('{"and",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 0, 0, 0, 0, 1});
    vecs.push_back('{"or",        4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'h0F0F_00F0, 0, 0, 0, 0, 1});
    vecs.push_back('{"nor",       4'b0101, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1});
    vecs.push_back('{"slt_t",     4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 0, 0, 0, 0, 1});
    vecs.push_back('{"slt_f",     4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1, 0, 0, 0, 1});
    vecs.push_back('{"illegal",   4'b1111, 32'h55, 32'h66, 5'd3, 32'h0, 1, 0, 0, 1, 1});
`ifdef ALU_MUL_EN
    vecs.push_back('{"mul",       4'b1110, 32'h0001_0003, 32'h7, 5'd0, 32'h0007_0015, 0, 0, 0, 0, 33});
`else
    vecs.push_back('{"mul_off",   4'b1110, 32'h0001_0003, 32'h7, 5'd0, 32'h0, 1, 0, 0, 1, 1});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, res, flg, lat, leak);
      check({vecs[i].name, "_result"}, res, vecs[i].res);
      check({vecs[i].name, "_flags"}, flg, {vecs[i].e, vecs[i].v, vecs[i].c, vecs[i].z});
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      if (vecs[i].lat > 1) check({vecs[i].name, "_in_ready_low"}, leak, 0);
    end

    // Backpressure: SUB result held for 3 cycles, queued ADD waits.
    @(negedge clk);
    bus.out_ready = 0; bus.alu_ctrl = 4'b0010; bus.a = 5; bus.b = 7; bus.in_valid = 1;
    @(negedge clk);
    bus.alu_ctrl = 4'b0000; bus.a = 10; bus.b = 20;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid",    bus.out_valid, 1);
      check("bp_result",   bus.result, 32'hFFFF_FFFE);
      check("bp_cout",     bus.cout, 0);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1;
    #1 check("bp_ready_rise", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 0;
    check("bp_next_valid",  bus.out_valid, 1);
    check("bp_next_result", bus.result, 30);
    @(negedge clk);
    check("bp_drained", bus.out_valid, 0);

    // Back-to-back issue with out_ready high: one result per clock.
    for (int i = 0; i < 5; i++) begin
      bus.alu_ctrl = 4'b0000; bus.a = i; bus.b = 100; bus.in_valid = 1;
      @(negedge clk);
      check("b2b_valid",  bus.out_valid, 1);
      check("b2b_result", bus.result, 100 + i);
    end
    bus.in_valid = 0;
    @(negedge clk);

    // Asynchronous reset while a result (or a MUL) is in flight.
    bus.alu_ctrl = MUL_EN ? 4'b1110 : 4'b0000;
    bus.a = 32'h1234; bus.b = 32'h5; bus.in_valid = 1; bus.out_ready = 0;
    @(negedge clk);
    bus.in_valid = 0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid",    bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_result",   bus.result, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1;
    leak = 0;
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clk);
      if (bus.out_valid) leak = 1;
    end
    check("mid_rst_discarded", leak, 0);

    // Randomised ops against the reference model.
    ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0001, 4'b0101, 4'b0111,
            4'b1010, 4'b1011, 4'b1100, 4'b1110};
    corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] ra, rb;
      logic [4:0]   rs;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rs = 5'($urandom);
      m  = model(op, ra, rb, rs);
      run_op(op, ra, rb, rs, res, flg, lat, leak);
      check($sformatf("rnd%0d_op%h_result", i, op), res, m.res);
      check($sformatf("rnd%0d_op%h_flags", i, op), flg, {m.e, m.v, m.c, m.z});
      check($sformatf("rnd%0d_op%h_latency", i, op), lat, m.lat);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the datapath ALU. It accepts one operation per valid/ready handshake and registers the result with zero/carry/overflow flags. Single-cycle operations complete with 1-cycle latency. An optional iterative shift-add multiplier completes in WIDTH+1 cycles. It sits between the register-file read stage and writeback, and stalls issue through `in_ready` while busy.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; power of two, ≥8.
- `SHAMT_W`, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (shift source).
- `alu_ctrl`  in  4  opcode.
- `shamt`  in  SHAMT_W  shift amount.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zout`  out  1  result == 0.
- `cout`  out  1  carry-out (ADD); NOT borrow (SUB); 0 for other ops.
- `ovf`  out  1  signed overflow (ADD/SUB); 0 for other ops.
- `err`  out  1  illegal opcode was issued.

## Operation
- Opcodes: 0000 ADD, 0010 SUB, 0100 AND, 0001 OR, 0101 NOR, 0111 SLT (signed, result 1/0), 1010 SLL, 1011 SRL, 1100 SRA, 1110 MUL (low WIDTH bits, unsigned).
- Shifts operate on `b` by `shamt`. shamt=0 returns `b` unchanged.
- Illegal opcode (any other, or MUL when compiled out): result=0, zout=1, err=1, completes in 1 cycle.
- FSM states:
  - IDLE: on a request, go to DONE; for MUL, go to MUL instead.
  - MUL: run WIDTH iterations, then go to DONE.
  - DONE: when `out_ready` is high, go to IDLE. If a new request is accepted in the same cycle, go directly to DONE or MUL.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from `out_ready`.
- Request accepted ⇔ `in_valid & in_ready`. Operands and opcode are captured on acceptance, and later input changes are ignored.
- Multiplier: each cycle, if b_reg[0], acc += a_reg. Then a_reg <<= 1, b_reg >>= 1, and the counter increments. The counter wraps at WIDTH−1 → DONE.
- Flags are computed on the final result only. `cout`/`ovf` use a WIDTH+1-bit sum. SUB = a + ~b + 1.
- `result`/flags hold stable while `out_valid` is high and `out_ready` is low. No output change without a handshake.

## Timing
- Reset (asynchronous, any state, including mid-MUL): state=IDLE, out_valid=0, result=0, zout=0, cout=0, ovf=0, err=0, counter=0. An in-progress MUL is discarded.
- Single-cycle op accepted at edge N → out_valid high after edge N (visible in cycle N+1).
- MUL accepted at edge N → out_valid after edge N+WIDTH+1.
- Back-to-back issue: with out_ready tied high, one single-cycle op per clock.
- `in_valid` with `in_ready` low: the request is held off and not captured. The requester keeps `in_valid` asserted.

## Configuration
- `ALU_MUL_EN` defined: MUL opcode, MUL state, counter and accumulator are present.
- Not defined: no multiplier logic; 1110 is treated as illegal (err=1, result 0); every op takes 1 cycle.

## Structure
- Package `alu_pkg`: opcode localparams (ALU_ADD … ALU_MUL), FSM state encoding, flag bit positions.
- Sub-module `alu_mul_iter` (shift-add engine: start, done, a, b, product), instantiated only under `ALU_MUL_EN`.
- The combinational op datapath stays in `alu_mc`.

## Test plan
- Reset mid-MUL (assert at cycle 5 of a MUL) → next cycle out_valid=0, in_ready=1, result=0.
- ADD a=0xFFFFFFFF, b=1 → result=0, zout=1, cout=1, ovf=0. ADD 0x7FFFFFFF+1 → result=0x80000000, ovf=1.
- SRA b=0x80000000, shamt=4 → 0xF8000000. SRL of the same → 0x08000000. SLL shamt=0, b=0x1234 → 0x1234.
- MUL a=0x0001_0003, b=7 (ALU_MUL_EN) → out_valid exactly 33 cycles after acceptance, result=0x0007_0015. in_ready=0 throughout.
- Backpressure: out_ready=0 for 3 cycles after SUB 5−7 → result 0xFFFFFFFE held stable, cout=0. New in_valid is not accepted until out_ready rises.
- Illegal opcode 1111 → err=1, result=0, 1-cycle latency. Without `ALU_MUL_EN`, 1110 gives the same response.
